id_stage: RTL
=============

Name: id_stage

Overview:
- Instruction-decode stage of the 5-stage RV32I core; sits between the IF/ID latch and EX.
- Drives register-file read addresses and read enable, generates immediates and control, detects load-use hazards, and owns the ID/EX pipeline register.
- The register file reads on the falling edge of the same cycle, so operand data is captured into ID/EX at the next rising edge.

Parameters:
DATA_SIZE, 32, datapath/instruction/PC width
REG_ADDR_SIZE, 6, register-file address width (MSB always 0)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-low
if_valid  input  1  IF/ID holds a valid instruction
if_inst  input  DATA_SIZE  instruction word
if_pc  input  DATA_SIZE  instruction PC
rf_rs1_data  input  DATA_SIZE  register-file rs1 read data (valid after falling edge)
rf_rs2_data  input  DATA_SIZE  register-file rs2 read data
ex_flush  input  1  taken branch/jump resolved in EX; kill ID contents
ex_hold  input  1  downstream stall; freeze ID/EX
rf_rs1_addr  output  REG_ADDR_SIZE  {1'b0, inst[19:15]}
rf_rs2_addr  output  REG_ADDR_SIZE  {1'b0, inst[24:20]}
rf_read  output  1  register-file read enable
id_stall  output  1  freeze PC and IF/ID
ex_valid  output  1  ID/EX valid
ex_pc  output  DATA_SIZE  PC
ex_rs1_data, ex_rs2_data  output  DATA_SIZE  operands
ex_imm  output  DATA_SIZE  sign-extended immediate
ex_rs1_addr, ex_rs2_addr, ex_rd_addr  output  REG_ADDR_SIZE  for forwarding/writeback
ex_alu_op  output  4  ALU opcode {funct7[5], funct3}; ADD (0000) for load/store/AUIPC/JAL/JALR
ex_funct3  output  3  raw funct3
ex_alu_src  output  1  1 = use immediate
ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump  output  1  control

Behaviour:
- Reset (rst==0 at a rising edge): all ID/EX outputs 0, including ex_valid=0. Reset overrides all other inputs, including mid-stall.
- Combinational outputs:
  - rf_rs1_addr and rf_rs2_addr come from if_inst directly.
  - rf_read = if_valid, also held 1 during a stall so the retry re-reads.
  - id_stall = load_use | (ex_hold & ~ex_flush).
- Decoded opcodes: R 0110011, OP-IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111.
- Immediate formats:
  - I, S, B, U and J formats, sign-extended from inst[31].
  - B and J have bit0 = 0.
  - U = {inst[31:12], 12'b0}.
  - R-type imm = 0.
  - SRAI sets alu_op[3] from inst[30]; other OP-IMM instructions force alu_op[3] = 0.
- Source-register usage:
  - uses_rs1 for all opcodes except LUI, AUIPC, JAL.
  - uses_rs2 for R, STORE, BRANCH only.
- rd / reg_write:
  - rd_addr is forced to 0 and reg_write to 0 for STORE and BRANCH.
  - reg_write is 0 when rd == 0.
- load_use = if_valid & ex_valid & ex_mem_read & ex_rd_addr!=0 & ((uses_rs1 & rs1==ex_rd_addr) | (uses_rs2 & rs2==ex_rd_addr)).
- ID/EX update priority at each rising edge:
  1. reset
  2. ex_flush: load a bubble (ex_valid=0, all control 0)
  3. ex_hold: keep all ID/EX contents
  4. load_use: load a bubble
  5. normal: load the decoded fields; ex_valid = if_valid & legal opcode
- A bubble clears ex_valid and all five control bits; data fields are don't-care, but the implementation clears them to 0.
- Latency: instruction present in cycle N, values on ex_* in cycle N+1.
- Writeback to the same register in cycle N is visible through the falling-edge read; no ID bypass.
- Load-use stall lasts exactly 1 cycle; the retry sees ex_mem_read=0 (bubble).
- Illegal opcode: decodes as a bubble.

Optional Feature:
- Macro ID_ILLEGAL_TRAP_EN.
- Defined: adds output ex_illegal (1 bit).
  - An illegal opcode with if_valid loads ex_valid=1, ex_illegal=1 and all controls 0, with ex_pc = if_pc.
  - ex_illegal is cleared by reset, flush and bubble.
- Undefined: no port; illegal opcodes produce a bubble.

Test Plan:
- Reset: rst=0 for 2 cycles with if_valid=1, inst ADD -> ex_valid=0 and all ex_* = 0; after rst=1 the first instruction appears 1 cycle later.
- Decode: ADDI x5,x1,-3 (0xFFD08293), rf_rs1_data=10 -> next cycle ex_imm=0xFFFFFFFD, ex_rd_addr=5, ex_alu_src=1, ex_reg_write=1, ex_rs1_data=10.
- Immediates: SW x2,8(x3) -> imm=8, mem_write=1, reg_write=0. BEQ with offset -4 -> imm=0xFFFFFFFC. LUI x7,0x12345 -> imm=0x12345000. JAL x1,+2048 -> imm=0x00000800.
- Load-use: LW x6,0(x1) followed by ADD x7,x6,x2 -> id_stall=1 for exactly 1 cycle and a bubble enters EX; the ADD enters the next cycle. The same sequence with LUI x6 after the LW gives no stall. LW x0 followed by ADD x7,x0,x2 gives no stall.
- Flush vs hold: ex_flush=1 and ex_hold=1 together -> bubble, id_stall=0. ex_hold=1 alone for 3 cycles -> ex_* frozen, id_stall=1.
- Write/read same cycle: WB writes x9=0xA5A5A5A5 while ADD x10,x9,x0 is in ID -> ex_rs1_data=0xA5A5A5A5. Under ID_ILLEGAL_TRAP_EN, opcode 0x7F -> ex_illegal=1, ex_valid=1.

Source files
------------

// File: rtl/id_stage_if.sv
// Bundle between the IF/ID latch, register file, EX stage and the ID stage.
// ID_ILLEGAL_TRAP_EN adds the ex_illegal signal.
interface id_stage_if #(
    parameter int DATA_SIZE     = 32,
    parameter int REG_ADDR_SIZE = 6
);
    logic                     if_valid;
    logic [DATA_SIZE-1:0]     if_inst;
    logic [DATA_SIZE-1:0]     if_pc;
    logic [DATA_SIZE-1:0]     rf_rs1_data;
    logic [DATA_SIZE-1:0]     rf_rs2_data;
    logic                     ex_flush;
    logic                     ex_hold;
    logic [REG_ADDR_SIZE-1:0] rf_rs1_addr;
    logic [REG_ADDR_SIZE-1:0] rf_rs2_addr;
    logic                     rf_read;
    logic                     id_stall;
    logic                     ex_valid;
    logic [DATA_SIZE-1:0]     ex_pc;
    logic [DATA_SIZE-1:0]     ex_rs1_data;
    logic [DATA_SIZE-1:0]     ex_rs2_data;
    logic [DATA_SIZE-1:0]     ex_imm;
    logic [REG_ADDR_SIZE-1:0] ex_rs1_addr;
    logic [REG_ADDR_SIZE-1:0] ex_rs2_addr;
    logic [REG_ADDR_SIZE-1:0] ex_rd_addr;
    logic [3:0]               ex_alu_op;
    logic [2:0]               ex_funct3;
    logic                     ex_alu_src;
    logic                     ex_mem_read;
    logic                     ex_mem_write;
    logic                     ex_reg_write;
    logic                     ex_branch;
    logic                     ex_jump;
`ifdef ID_ILLEGAL_TRAP_EN
    logic                     ex_illegal;
`endif

    modport master (
        input  if_valid, if_inst, if_pc, rf_rs1_data, rf_rs2_data, ex_flush, ex_hold,
`ifdef ID_ILLEGAL_TRAP_EN
        output ex_illegal,
`endif
        output rf_rs1_addr, rf_rs2_addr, rf_read, id_stall, ex_valid, ex_pc,
               ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
               ex_alu_op, ex_funct3, ex_alu_src, ex_mem_read, ex_mem_write,
               ex_reg_write, ex_branch, ex_jump
    );

    modport slave (
        output if_valid, if_inst, if_pc, rf_rs1_data, rf_rs2_data, ex_flush, ex_hold,
`ifdef ID_ILLEGAL_TRAP_EN
        input  ex_illegal,
`endif
        input  rf_rs1_addr, rf_rs2_addr, rf_read, id_stall, ex_valid, ex_pc,
               ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
               ex_alu_op, ex_funct3, ex_alu_src, ex_mem_read, ex_mem_write,
               ex_reg_write, ex_branch, ex_jump
    );
endinterface

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: decode, immediates, load-use detection, ID/EX register.
// Define ID_ILLEGAL_TRAP_EN to pass illegal opcodes to EX flagged as ex_illegal.
module id_stage #(
    parameter int DATA_SIZE     = 32,
    parameter int REG_ADDR_SIZE = 6
) (
    input  logic         clk,
    input  logic         rst,
    id_stage_if.master   bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic                     valid;
        logic [DATA_SIZE-1:0]     pc;
        logic [DATA_SIZE-1:0]     rs1_data;
        logic [DATA_SIZE-1:0]     rs2_data;
        logic [DATA_SIZE-1:0]     imm;
        logic [REG_ADDR_SIZE-1:0] rs1_addr;
        logic [REG_ADDR_SIZE-1:0] rs2_addr;
        logic [REG_ADDR_SIZE-1:0] rd_addr;
        logic [3:0]               alu_op;
        logic [2:0]               funct3;
        logic                     alu_src;
        logic                     mem_read;
        logic                     mem_write;
        logic                     reg_write;
        logic                     branch;
        logic                     jump;
`ifdef ID_ILLEGAL_TRAP_EN
        logic                     illegal;
`endif
    } idex_t;

    idex_t idex_reg, idex_next;

    logic [DATA_SIZE-1:0]     inst;
    logic [6:0]               opcode;
    logic [2:0]               funct3;
    logic [REG_ADDR_SIZE-1:0] rs1, rs2, rd;
    logic                     legal, uses_rs1, uses_rs2, rd_kept;
    logic                     dec_alu_src, dec_mem_read, dec_mem_write, dec_wr, dec_branch, dec_jump;
    logic [3:0]               dec_alu_op;
    logic [DATA_SIZE-1:0]     dec_imm;
    logic                     load_use;

    assign inst   = bus.if_inst;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];
    assign rs1    = {{(REG_ADDR_SIZE-5){1'b0}}, inst[19:15]};
    assign rs2    = {{(REG_ADDR_SIZE-5){1'b0}}, inst[24:20]};
    assign rd     = {{(REG_ADDR_SIZE-5){1'b0}}, inst[11:7]};

    always_comb begin
        legal         = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b0;
        rd_kept       = 1'b1;
        dec_imm       = '0;
        dec_alu_op    = 4'b0000;
        dec_alu_src   = 1'b1;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_wr        = 1'b1;
        dec_branch    = 1'b0;
        dec_jump      = 1'b0;
        case (opcode)
            OP_R: begin
                uses_rs2    = 1'b1;
                dec_alu_src = 1'b0;
                dec_alu_op  = {inst[30], funct3};
            end
            OP_IMM: begin
                dec_imm    = {{(DATA_SIZE-12){inst[31]}}, inst[31:20]};
                // Only the shift-right-immediate encoding carries funct7[5] as an op bit
                dec_alu_op = {(funct3 == 3'b101) & inst[30], funct3};
            end
            OP_LOAD: begin
                dec_imm      = {{(DATA_SIZE-12){inst[31]}}, inst[31:20]};
                dec_mem_read = 1'b1;
            end
            OP_JALR: begin
                dec_imm  = {{(DATA_SIZE-12){inst[31]}}, inst[31:20]};
                dec_jump = 1'b1;
            end
            OP_STORE: begin
                dec_imm       = {{(DATA_SIZE-12){inst[31]}}, inst[31:25], inst[11:7]};
                uses_rs2      = 1'b1;
                rd_kept       = 1'b0;
                dec_wr        = 1'b0;
                dec_mem_write = 1'b1;
            end
            OP_BRANCH: begin
                dec_imm     = {{(DATA_SIZE-12){inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
                uses_rs2    = 1'b1;
                rd_kept     = 1'b0;
                dec_wr      = 1'b0;
                dec_alu_src = 1'b0;
                dec_branch  = 1'b1;
            end
            OP_JAL: begin
                dec_imm  = {{(DATA_SIZE-20){inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
                uses_rs1 = 1'b0;
                dec_jump = 1'b1;
            end
            OP_LUI, OP_AUIPC: begin
                dec_imm  = {{(DATA_SIZE-31){inst[31]}}, inst[30:12], 12'b0};
                uses_rs1 = 1'b0;
            end
            default: begin
                legal       = 1'b0;
                uses_rs1    = 1'b0;
                rd_kept     = 1'b0;
                dec_wr      = 1'b0;
                dec_alu_src = 1'b0;
            end
        endcase
    end

    assign load_use = bus.if_valid & idex_reg.valid & idex_reg.mem_read & (idex_reg.rd_addr != '0) &
                      ((uses_rs1 & (rs1 == idex_reg.rd_addr)) | (uses_rs2 & (rs2 == idex_reg.rd_addr)));

    assign bus.rf_rs1_addr = rs1;
    assign bus.rf_rs2_addr = rs2;
    assign bus.id_stall    = load_use | (bus.ex_hold & ~bus.ex_flush);
    // Keep reading during a stall so the retried instruction sees fresh operands
    assign bus.rf_read     = bus.if_valid | bus.id_stall;

    always_comb begin
        idex_next = idex_reg;
        if (bus.ex_flush) begin
            idex_next = '0;
        end else if (bus.ex_hold) begin
            idex_next = idex_reg;
        end else if (load_use) begin
            idex_next = '0;
        end else begin
            idex_next.valid     = bus.if_valid & legal;
            idex_next.pc        = bus.if_pc;
            idex_next.rs1_data  = bus.rf_rs1_data;
            idex_next.rs2_data  = bus.rf_rs2_data;
            idex_next.imm       = dec_imm;
            idex_next.rs1_addr  = rs1;
            idex_next.rs2_addr  = rs2;
            idex_next.rd_addr   = rd_kept ? rd : '0;
            idex_next.alu_op    = dec_alu_op;
            idex_next.funct3    = funct3;
            idex_next.alu_src   = dec_alu_src;
            idex_next.mem_read  = bus.if_valid & dec_mem_read;
            idex_next.mem_write = bus.if_valid & dec_mem_write;
            idex_next.reg_write = bus.if_valid & dec_wr & (rd != '0);
            idex_next.branch    = bus.if_valid & dec_branch;
            idex_next.jump      = bus.if_valid & dec_jump;
`ifdef ID_ILLEGAL_TRAP_EN
            idex_next.valid     = bus.if_valid;
            idex_next.illegal   = bus.if_valid & ~legal;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) idex_reg <= '0;
        else      idex_reg <= idex_next;
    end

    assign bus.ex_valid     = idex_reg.valid;
    assign bus.ex_pc        = idex_reg.pc;
    assign bus.ex_rs1_data  = idex_reg.rs1_data;
    assign bus.ex_rs2_data  = idex_reg.rs2_data;
    assign bus.ex_imm       = idex_reg.imm;
    assign bus.ex_rs1_addr  = idex_reg.rs1_addr;
    assign bus.ex_rs2_addr  = idex_reg.rs2_addr;
    assign bus.ex_rd_addr   = idex_reg.rd_addr;
    assign bus.ex_alu_op    = idex_reg.alu_op;
    assign bus.ex_funct3    = idex_reg.funct3;
    assign bus.ex_alu_src   = idex_reg.alu_src;
    assign bus.ex_mem_read  = idex_reg.mem_read;
    assign bus.ex_mem_write = idex_reg.mem_write;
    assign bus.ex_reg_write = idex_reg.reg_write;
    assign bus.ex_branch    = idex_reg.branch;
    assign bus.ex_jump      = idex_reg.jump;
`ifdef ID_ILLEGAL_TRAP_EN
    assign bus.ex_illegal   = idex_reg.illegal;
`endif
endmodule
